// File: rtl/xor_gate_pkg.sv
// Shared constants and helpers for the registered bitwise XOR unit.
// Parameter legality is checked at elaboration through params_ok_f.
package xor_gate_pkg;

  localparam int unsigned MAX_WIDTH   = 64;
  localparam int unsigned MAX_LATENCY = 4;

  function automatic int unsigned popcount_f(input logic [MAX_WIDTH-1:0] value);
    int unsigned count;
    count = 0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      count += int'(value[i]);
    end
    return count;
  endfunction

  function automatic bit params_ok_f(input int unsigned width, input int unsigned latency);
    return (width >= 1) && (width <= MAX_WIDTH) && (latency <= MAX_LATENCY);
  endfunction

endpackage

// File: rtl/xor_gate_if.sv
// Operand/result bundle for xor_gate. The master drives operands;
// the slave (the XOR unit) returns the result with its derived outputs.
interface xor_gate_if #(
    parameter int unsigned WIDTH = 1
);

    localparam int unsigned CountW = $clog2(WIDTH + 1);

    logic              in_valid;
    logic [WIDTH-1:0]  I1;
    logic [WIDTH-1:0]  I2;
    logic              out_valid;
    logic [WIDTH-1:0]  O;
    logic              parity;
    logic [CountW-1:0] diff_count;

    modport master (
        output in_valid, I1, I2,
        input  out_valid, O, parity, diff_count
    );

    modport slave (
        input  in_valid, I1, I2,
        output out_valid, O, parity, diff_count
    );

endinterface

// File: rtl/xor_pipe_stage.sv
// One pipeline register for the XOR result plus its valid bit.
// Cleared asynchronously by rst so in-flight data is dropped at once.
module xor_pipe_stage #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_data,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q_data,
    output logic             q_valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_data  <= '0;
            q_valid <= 1'b0;
        end else begin
            q_data  <= d_data;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/xor_gate.sv
// Registered, width-parameterised bitwise XOR with valid tracking,
// parity and Hamming-distance outputs derived from the final stage.
module xor_gate
  import xor_gate_pkg::*;
#(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned LATENCY = 1
) (
    input logic       clk,
    input logic       rst,
    xor_gate_if.slave bus
);

    localparam int unsigned CountW = $clog2(WIDTH + 1);

    if (!params_ok_f(WIDTH, LATENCY)) begin : g_param_err
        $error("xor_gate: WIDTH must be 1..64 and LATENCY 0..4");
    end

    // Index 0 is the combinational XOR; index LATENCY is the output stage.
    logic [WIDTH-1:0] data_s  [LATENCY+1];
    logic             valid_s [LATENCY+1];

    assign data_s[0]  = bus.I1 ^ bus.I2;
    assign valid_s[0] = bus.in_valid;

    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        xor_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .d_data (data_s[i]),
            .d_valid(valid_s[i]),
            .q_data (data_s[i+1]),
            .q_valid(valid_s[i+1])
        );
    end

    logic [MAX_WIDTH-1:0] o_ext;

    always_comb begin
        o_ext              = '0;
        o_ext[WIDTH-1:0]   = data_s[LATENCY];
    end

    assign bus.O          = data_s[LATENCY];
    assign bus.out_valid  = valid_s[LATENCY];
    assign bus.parity     = ^data_s[LATENCY];
    assign bus.diff_count = CountW'(popcount_f(o_ext));

endmodule

// File: tb/tb_xor_gate.sv
// Self-checking bench for xor_gate across four width/latency configurations,
// driven from a shared vector table and scored through per-instance queues.
module tb_xor_gate;

    typedef struct packed {
        logic       v;
        logic [7:0] o;
        logic       par;
        logic [3:0] dc;
    } exp_t;

    typedef struct {
        logic       v;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] o;
        logic       par;
        logic [3:0] dc;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       v;
    logic [7:0] a;
    logic [7:0] b;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q_w1l1[$];
    exp_t q_w8l0[$];
    exp_t q_w8l2[$];
    exp_t q_w8l3[$];

    xor_gate_if #(.WIDTH(1)) if_w1l1 ();
    xor_gate_if #(.WIDTH(8)) if_w8l0 ();
    xor_gate_if #(.WIDTH(8)) if_w8l2 ();
    xor_gate_if #(.WIDTH(8)) if_w8l3 ();

    assign if_w1l1.in_valid = v;
    assign if_w1l1.I1       = a[0];
    assign if_w1l1.I2       = b[0];
    assign if_w8l0.in_valid = v;
    assign if_w8l0.I1       = a;
    assign if_w8l0.I2       = b;
    assign if_w8l2.in_valid = v;
    assign if_w8l2.I1       = a;
    assign if_w8l2.I2       = b;
    assign if_w8l3.in_valid = v;
    assign if_w8l3.I1       = a;
    assign if_w8l3.I2       = b;

    xor_gate #(.WIDTH(1), .LATENCY(1)) u_w1l1 (.clk(clk), .rst(rst), .bus(if_w1l1));
    xor_gate #(.WIDTH(8), .LATENCY(0)) u_w8l0 (.clk(clk), .rst(rst), .bus(if_w8l0));
    xor_gate #(.WIDTH(8), .LATENCY(2)) u_w8l2 (.clk(clk), .rst(rst), .bus(if_w8l2));
    xor_gate #(.WIDTH(8), .LATENCY(3)) u_w8l3 (.clk(clk), .rst(rst), .bus(if_w8l3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic score(input string name, input exp_t e, input logic ov,
                         input logic [7:0] o, input logic par, input logic [3:0] dc);
        check({name, " out_valid"}, {7'b0, ov}, {7'b0, e.v});
        if (e.v) begin
            check({name, " O"}, o, e.o);
            check({name, " parity"}, {7'b0, par}, {7'b0, e.par});
            check({name, " diff_count"}, {4'b0, dc}, {4'b0, e.dc});
        end
    endtask

    task automatic score_all();
        if (q_w1l1.size() > 1)
            score("w1l1", q_w1l1.pop_front(), if_w1l1.out_valid, {7'b0, if_w1l1.O},
                  if_w1l1.parity, {3'b0, if_w1l1.diff_count});
        else
            check("w1l1 idle out_valid", {7'b0, if_w1l1.out_valid}, 8'h00);
        if (q_w8l0.size() > 0)
            score("w8l0", q_w8l0.pop_front(), if_w8l0.out_valid, if_w8l0.O,
                  if_w8l0.parity, if_w8l0.diff_count);
        if (q_w8l2.size() > 2)
            score("w8l2", q_w8l2.pop_front(), if_w8l2.out_valid, if_w8l2.O,
                  if_w8l2.parity, if_w8l2.diff_count);
        else
            check("w8l2 idle out_valid", {7'b0, if_w8l2.out_valid}, 8'h00);
        if (q_w8l3.size() > 3)
            score("w8l3", q_w8l3.pop_front(), if_w8l3.out_valid, if_w8l3.O,
                  if_w8l3.parity, if_w8l3.diff_count);
        else
            check("w8l3 idle out_valid", {7'b0, if_w8l3.out_valid}, 8'h00);
    endtask

    // Drive one operand pair just after the edge, queue its expectations, then score.
    task automatic step(input vec_t r);
        exp_t e8;
        exp_t e1;
        logic o1;
        @(posedge clk);
        #1;
        v = r.v;
        a = r.a;
        b = r.b;
        o1 = r.a[0] ^ r.b[0];
        e8 = '{v: r.v, o: r.o, par: r.par, dc: r.dc};
        e1 = '{v: r.v, o: {7'b0, o1}, par: o1, dc: {3'b0, o1}};
        q_w1l1.push_back(e1);
        q_w8l0.push_back(e8);
        q_w8l2.push_back(e8);
        q_w8l3.push_back(e8);
        #1;
        score_all();
    endtask

    task automatic check_regs_cleared(input string tag);
        check({tag, " w1l1 O"}, {7'b0, if_w1l1.O}, 8'h00);
        check({tag, " w1l1 out_valid"}, {7'b0, if_w1l1.out_valid}, 8'h00);
        check({tag, " w1l1 parity"}, {7'b0, if_w1l1.parity}, 8'h00);
        check({tag, " w1l1 diff_count"}, {7'b0, if_w1l1.diff_count}, 8'h00);
        check({tag, " w8l2 O"}, if_w8l2.O, 8'h00);
        check({tag, " w8l2 out_valid"}, {7'b0, if_w8l2.out_valid}, 8'h00);
        check({tag, " w8l2 diff_count"}, {4'b0, if_w8l2.diff_count}, 8'h00);
        check({tag, " w8l3 O"}, if_w8l3.O, 8'h00);
        check({tag, " w8l3 out_valid"}, {7'b0, if_w8l3.out_valid}, 8'h00);
        check({tag, " w8l3 parity"}, {7'b0, if_w8l3.parity}, 8'h00);
    endtask

    task automatic flush();
        q_w1l1.delete();
        q_w8l0.delete();
        q_w8l2.delete();
        q_w8l3.delete();
    endtask

    vec_t tbl[12];
    vec_t idle;

    initial begin
        tbl[0]  = '{1'b1, 8'hF0, 8'h3C, 8'hCC, 1'b0, 4'd4};
        tbl[1]  = '{1'b1, 8'hFF, 8'h00, 8'hFF, 1'b0, 4'd8};
        tbl[2]  = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 4'd0};
        tbl[3]  = '{1'b1, 8'h00, 8'h01, 8'h01, 1'b1, 4'd1};
        tbl[4]  = '{1'b1, 8'h01, 8'h00, 8'h01, 1'b1, 4'd1};
        tbl[5]  = '{1'b1, 8'h01, 8'h01, 8'h00, 1'b0, 4'd0};
        tbl[6]  = '{1'b0, 8'hxx, 8'hxx, 8'h00, 1'b0, 4'd0};
        tbl[7]  = '{1'b1, 8'hA5, 8'h5A, 8'hFF, 1'b0, 4'd8};
        tbl[8]  = '{1'b1, 8'h80, 8'h01, 8'h81, 1'b0, 4'd2};
        tbl[9]  = '{1'b1, 8'h13, 8'h31, 8'h22, 1'b0, 4'd2};
        tbl[10] = '{1'b1, 8'h6E, 8'h00, 8'h6E, 1'b1, 4'd5};
        tbl[11] = '{1'b1, 8'h07, 8'h00, 8'h07, 1'b1, 4'd3};
        idle    = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 4'd0};

        // Reset held: registered outputs stay clear, combinational instance ignores rst.
        rst = 1'b1;
        v   = 1'b0;
        a   = 8'h00;
        b   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        v = 1'b1;
        a = 8'hFF;
        @(posedge clk);
        #2;
        check_regs_cleared("reset");
        check("reset w8l0 O", if_w8l0.O, 8'hFF);
        check("reset w8l0 diff_count", {4'b0, if_w8l0.diff_count}, 8'h08);
        check("reset w8l0 out_valid", {7'b0, if_w8l0.out_valid}, 8'h01);
        v = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) step(tbl[i]);

        // Asynchronous reset between edges with w1l1 holding a valid O=1.
        step(tbl[4]);
        step(tbl[1]);
        #2;
        rst = 1'b1;
        v   = 1'b0;
        #1;
        check_regs_cleared("async_rst");
        check("async_rst w8l0 O", if_w8l0.O, 8'hFF);
        #1;
        rst = 1'b0;
        flush();

        for (int i = 7; i < 12; i++) step(tbl[i]);
        repeat (4) step(idle);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xor_gate.md
Name: xor_gate

Overview:
- Registered, width-parameterised bitwise XOR unit: O = I1 ^ I2, with valid tracking and derived parity/difference-count outputs.
- Used as a leaf logic-gate block. With WIDTH=1 it is the scalar two-input XOR gate; wider instances serve as Hamming-difference/compare helpers.
- Pipeline depth is set at elaboration time and defaults to a single register stage.

Parameters:
- WIDTH, 1, operand and result width in bits (legal range 1..64).
- LATENCY, 1, number of register stages from input to output (legal range 0..4; 0 = purely combinational path).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  I1/I2 carry a valid operand pair this cycle
- I1  input  WIDTH  operand 1
- I2  input  WIDTH  operand 2
- out_valid  output  1  O/parity/diff_count are valid this cycle
- O  output  WIDTH  bitwise XOR result, I1 ^ I2
- parity  output  1  reduction XOR of O (odd number of differing bits)
- diff_count  output  $clog2(WIDTH+1)  population count of O (Hamming distance of I1 and I2)

Behaviour:
- One clock; reset is asynchronous and active-high. rst is the only reset; there is no synchronous clear.
- Reset state: all pipeline registers clear immediately on rst assertion, independent of clk. O=0, parity=0, diff_count=0, out_valid=0.
- Reset release is clean: the first capture occurs at the first rising clk edge with rst low.
- LATENCY=N>0:
  - Operands sampled on clock edge k appear on O at edge k+N-1+1, i.e. N cycles later.
  - in_valid travels with the data and emerges as out_valid.
- LATENCY=0:
  - All outputs are combinational functions of the inputs; out_valid = in_valid.
  - rst has no effect in this mode.
- Data registers capture every cycle regardless of in_valid. Invalid cycles produce don't-care data but a correct out_valid=0. This keeps the datapath free of enables.
- parity and diff_count derive from the final-stage O in the same cycle as O. They add no extra latency.
- Width rule: diff_count width is $clog2(WIDTH+1); with WIDTH=1 it is 1 bit. Maximum value is WIDTH (all bits differ). No overflow is possible.
- No handshake backpressure: the block accepts one operand pair per cycle, every cycle (throughput 1).
- Reset mid-operation: all in-flight data is discarded. out_valid stays 0 until new valid inputs have propagated LATENCY cycles after release.
- X on inputs when in_valid=0 must not corrupt out_valid.

Decomposition:
- Shared package xor_gate_pkg:
  - constants MAX_WIDTH=64 and MAX_LATENCY=4
  - function popcount_f
  - elaboration-time parameter checks (range asserts)
- Sub-module xor_pipe_stage: a single WIDTH+1-bit register (data + valid) with async active-high reset. It is instantiated LATENCY times via generate.
- The top level holds the XOR, the generate chain, and the parity/popcount logic.

Test Plan:
- WIDTH=1, LATENCY=1: I1=0, I2=1, in_valid=1 -> after 1 clk: O=1, parity=1, diff_count=1, out_valid=1.
- WIDTH=1 truth table: drive 00,01,10,11 on consecutive cycles -> O sequence 0,1,1,0 (one cycle late), out_valid held 1.
- WIDTH=8, LATENCY=2: I1=8'hF0, I2=8'h3C -> 2 clks later: O=8'hCC, parity=0, diff_count=4.
- Async reset: with O=1 valid, assert rst between edges -> O=0 and out_valid=0 immediately, before the next clk. Release rst -> out_valid stays 0 until new in_valid has propagated.
- WIDTH=8, LATENCY=0: I1=8'hFF, I2=8'h00 -> same cycle: O=8'hFF, diff_count=8, parity=0.
- Valid gating: in_valid pulse pattern 1,0,1 with LATENCY=3 -> out_valid pattern 1,0,1 starting 3 cycles later.
